// File: rtl/btn_pkg.sv
// Shared types, default timing and helpers for the push-button conditioner.
// Button index order doubles as arbitration priority (lowest index wins).
package btn_pkg;

  typedef enum logic [1:0] {
    BTN_UP    = 2'd0,
    BTN_DOWN  = 2'd1,
    BTN_LEFT  = 2'd2,
    BTN_RIGHT = 2'd3
  } btn_idx_e;

  localparam int NUM_BTNS = 4;

  // Defaults for a 25 MHz clock: 10 ms debounce, auto-repeat off.
  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_REPEAT_DELAY    = 0;
  localparam int DEF_REPEAT_PERIOD   = 125000;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Isolates the lowest set bit, i.e. the highest-priority request.
  function automatic logic [NUM_BTNS-1:0] grant_first(input logic [NUM_BTNS-1:0] req);
    return req & (~req + NUM_BTNS'(1));
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce counter, stable level and
// a registered one-cycle event flag for each accepted press or auto-repeat.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic flag
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);

  logic          sync1, sync2, stable;
  logic [DW-1:0] deb_cnt;
  logic          mismatch, deb_done, press, rep_fire;

  assign mismatch = (sync2 != stable);
  assign deb_done = mismatch && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign press    = deb_done && !sync2;

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, which is what makes the
  // sync1 -> sync2 chain a real two-stage synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      stable  <= 1'b1;
      deb_cnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (!mismatch) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        stable  <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  if (REPEAT_DELAY > 0) begin : g_repeat
    localparam int RW = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    logic [RW-1:0] rep_cnt;
    logic          rep_first;
    logic          held;
    logic [RW-1:0] target;

    // Held means low now and not being released on this edge.
    assign held     = !stable && !(deb_done && sync2);
    assign target   = rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    assign rep_fire = held && (rep_cnt == target);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (press || !held) begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end else if (rep_fire) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end else begin : g_no_repeat
    assign rep_fire = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag <= 1'b0;
    else        flag <= press || rep_fire;
  end

endmodule

// File: rtl/btn_input_conditioner.sv
// Four debounced button channels, a fixed-priority arbiter (Up > Down >
// Left > Right) and a registered active-low one-cycle pulse per button.
module btn_input_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Btn_Up_Raw,
  input  logic Btn_Down_Raw,
  input  logic Btn_Left_Raw,
  input  logic Btn_Right_Raw,
  output logic Btn_Up,
  output logic Btn_Down,
  output logic Btn_Left,
  output logic Btn_Right
);

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] flags;
  logic [NUM_BTNS-1:0] grant;
  logic [NUM_BTNS-1:0] btn_q;

  assign raw[BTN_UP]    = Btn_Up_Raw;
  assign raw[BTN_DOWN]  = Btn_Down_Raw;
  assign raw[BTN_LEFT]  = Btn_Left_Raw;
  assign raw[BTN_RIGHT] = Btn_Right_Raw;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (Clk),
      .rst_n(Rst_n),
      .raw  (raw[i]),
      .flag (flags[i])
    );
  end

  // Losing flags are simply dropped; nothing is queued for a later cycle.
  assign grant = grant_first(flags);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) btn_q <= '1;
    else        btn_q <= ~grant;
  end

  assign Btn_Up    = btn_q[BTN_UP];
  assign Btn_Down  = btn_q[BTN_DOWN];
  assign Btn_Left  = btn_q[BTN_LEFT];
  assign Btn_Right = btn_q[BTN_RIGHT];

endmodule

// File: tb/tb_btn_input_conditioner.sv
// Bench for btn_input_conditioner: one DUT with auto-repeat, one without,
// both checked every cycle against a sliding-window reference model.
module tb_btn_input_conditioner;

  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw   = 4'hF;   // bit 0 up, 1 down, 2 left, 3 right
  logic       up1, down1, left1, right1;
  logic       up2, down2, left2, right2;
  logic [3:0] out1, out2;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;

  btn_input_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut (
    .Clk(clk), .Rst_n(rst_n),
    .Btn_Up_Raw(raw[0]), .Btn_Down_Raw(raw[1]), .Btn_Left_Raw(raw[2]), .Btn_Right_Raw(raw[3]),
    .Btn_Up(up1), .Btn_Down(down1), .Btn_Left(left1), .Btn_Right(right1)
  );

  btn_input_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) u_dut_norep (
    .Clk(clk), .Rst_n(rst_n),
    .Btn_Up_Raw(raw[0]), .Btn_Down_Raw(raw[1]), .Btn_Left_Raw(raw[2]), .Btn_Right_Raw(raw[3]),
    .Btn_Up(up2), .Btn_Down(down2), .Btn_Left(left2), .Btn_Right(right2)
  );

  assign out1 = {right1, left1, down1, up1};
  assign out2 = {right2, left2, down2, up2};

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [3:0] f);
    logic [3:0] g;
    g = 4'h0;
    for (int i = 3; i >= 0; i--) if (f[i]) g = 4'h0 | (4'h1 << i);
    return g;
  endfunction

  // Reference model: stable level flips when the last D synchroniser
  // samples (delayed by the 2-FF chain) all disagree with it; repeats are
  // press_edge + RD + n*RP while the level stays low.
  logic [3:0] hist[$];
  logic [3:0] m_stable[2];
  logic [3:0] m_pend[2];
  logic [3:0] m_exp[2] = '{4'hF, 4'hF};
  int         m_press[2][4];
  logic [3:0] m_flags;
  logic [3:0] m_drop;
  logic       all_diff;
  int         m_rd, m_dist;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < D + 2; i++) hist.push_back(4'hF);
      for (int c = 0; c < 2; c++) begin
        m_stable[c] = 4'hF;
        m_pend[c]   = 4'h0;
        m_exp[c]    = 4'hF;
      end
    end else begin
      hist.push_back(raw);
      m_drop = hist.pop_front();
      for (int c = 0; c < 2; c++) begin
        m_rd      = (c == 0) ? RD : 0;
        m_exp[c]  = ~lowest(m_pend[c]);
        m_flags   = 4'h0;
        for (int b = 0; b < 4; b++) begin
          all_diff = 1'b1;
          for (int j = 2; j <= D + 1; j++)
            if (hist[D + 1 - j][b] == m_stable[c][b]) all_diff = 1'b0;
          if (all_diff) begin
            m_stable[c][b] = ~m_stable[c][b];
            if (!m_stable[c][b]) begin
              m_press[c][b] = cyc;
              m_flags[b]    = 1'b1;
            end
          end else if (!m_stable[c][b] && m_rd > 0) begin
            m_dist = cyc - m_press[c][b];
            if (m_dist >= m_rd && ((m_dist - m_rd) % RP) == 0) m_flags[b] = 1'b1;
          end
        end
        m_pend[c] = m_flags;
      end
    end
  end

  int log1[4][$];
  int log2[4][$];

  always @(negedge clk) begin
    check("out_rep",   int'(out1), int'(rst_n ? m_exp[0] : 4'hF));
    check("out_norep", int'(out2), int'(rst_n ? m_exp[1] : 4'hF));
    for (int b = 0; b < 4; b++) begin
      if (!out1[b]) log1[b].push_back(cyc);
      if (!out2[b]) log2[b].push_back(cyc);
    end
  end

  task automatic at(input int n);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < n);
  endtask

  task automatic clear_logs();
    for (int b = 0; b < 4; b++) begin
      log1[b].delete();
      log2[b].delete();
    end
  endtask

  function automatic int first1(input int b);
    return (log1[b].size() > 0) ? log1[b][0] : -1;
  endfunction

  function automatic int first2(input int b);
    return (log2[b].size() > 0) ? log2[b][0] : -1;
  endfunction

  typedef struct {
    logic [3:0] mask;   // buttons pressed together
    int         hold;   // cycles the raw level stays low
    logic [3:0] act;    // outputs expected to pulse at all
    int         n1;     // total pulses, repeat-enabled DUT
    int         n2;     // total pulses, repeat-disabled DUT
  } vec_t;

  vec_t tbl[9];
  int   b0, tot1, tot2, run[4];
  logic [3:0] act1, act2;

  initial begin
    tbl[0] = '{4'b0001, 15, 4'b0001, 1, 1};
    tbl[1] = '{4'b0001, 30, 4'b0001, 3, 1};
    tbl[2] = '{4'b0100,  7, 4'b0000, 0, 0};
    tbl[3] = '{4'b0100,  8, 4'b0100, 1, 1};
    tbl[4] = '{4'b1001, 15, 4'b0001, 1, 1};
    tbl[5] = '{4'b0110, 30, 4'b0010, 3, 1};
    tbl[6] = '{4'b1111, 40, 4'b0001, 5, 1};
    tbl[7] = '{4'b1000,  5, 4'b0000, 0, 0};
    tbl[8] = '{4'b1000, 20, 4'b1000, 1, 1};

    // Reset state
    #12;
    check("reset_out_rep",   int'(out1), 15);
    check("reset_out_norep", int'(out2), 15);
    at(3);
    rst_n = 1'b1;
    at(cyc + 20);

    // Table-driven presses
    for (int i = 0; i < 9; i++) begin
      clear_logs();
      b0  = cyc;
      raw = ~tbl[i].mask;
      at(b0 + tbl[i].hold);
      raw = 4'hF;
      at(b0 + tbl[i].hold + 30);
      tot1 = 0; tot2 = 0; act1 = 4'h0; act2 = 4'h0;
      for (int b = 0; b < 4; b++) begin
        tot1 += log1[b].size();
        tot2 += log2[b].size();
        act1[b] = (log1[b].size() > 0);
        act2[b] = (log2[b].size() > 0);
      end
      check($sformatf("tbl%0d_active_rep", i),   int'(act1), int'(tbl[i].act));
      check($sformatf("tbl%0d_active_norep", i), int'(act2), int'(tbl[i].act));
      check($sformatf("tbl%0d_count_rep", i),    tot1, tbl[i].n1);
      check($sformatf("tbl%0d_count_norep", i),  tot2, tbl[i].n2);
    end

    // Clean press: first low sample at edge b0+10, pulse after edge b0+20
    clear_logs(); b0 = cyc;
    at(b0 + 9);   raw[0] = 1'b0;
    at(b0 + 109); raw[0] = 1'b1;
    at(b0 + 140);
    check("clean_count_norep", log2[0].size(), 1);
    check("clean_time_norep",  first2(0), b0 + 20);
    check("clean_time_rep",    first1(0), b0 + 20);

    // Auto-repeat: pulses at P, P+20, P+25 ... P+55, then release
    clear_logs(); b0 = cyc;
    at(b0 + 9);  raw[1] = 1'b0;
    at(b0 + 67); raw[1] = 1'b1;
    at(b0 + 100);
    check("repeat_count", log1[1].size(), 9);
    for (int j = 0; j < 9; j++) begin
      if (j < log1[1].size())
        check($sformatf("repeat_time%0d", j), log1[1][j], (j == 0) ? b0 + 20 : b0 + 35 + 5 * j);
    end
    check("repeat_count_norep", log2[1].size(), 1);

    // Bounce rejection on Left, steady low from edge b0+40
    clear_logs(); b0 = cyc;
    at(b0 + 27); raw[2] = 1'b0;
    at(b0 + 32); raw[2] = 1'b1;
    at(b0 + 33); raw[2] = 1'b0;
    at(b0 + 38); raw[2] = 1'b1;
    at(b0 + 39); raw[2] = 1'b0;
    at(b0 + 60); raw[2] = 1'b1;
    at(b0 + 100);
    check("bounce_count_norep", log2[2].size(), 1);
    check("bounce_time_norep",  first2(2), b0 + 50);
    check("bounce_time_rep",    first1(2), b0 + 50);

    // Simultaneous Up and Right
    clear_logs(); b0 = cyc;
    at(b0 + 9);  raw[0] = 1'b0; raw[3] = 1'b0;
    at(b0 + 40); raw[0] = 1'b1; raw[3] = 1'b1;
    at(b0 + 80);
    check("simul_right_rep",   log1[3].size(), 0);
    check("simul_right_norep", log2[3].size(), 0);
    check("simul_up_time",     first1(0), b0 + 20);

    // Reset mid-debounce: Left low 5 samples, reset 3 cycles, raw stays low
    clear_logs(); b0 = cyc;
    at(b0 + 9);  raw[2] = 1'b0;
    at(b0 + 14); rst_n = 1'b0;
    #2;
    check("midreset_out_rep",   int'(out1), 15);
    check("midreset_out_norep", int'(out2), 15);
    at(b0 + 17); rst_n = 1'b1;
    at(b0 + 40); raw[2] = 1'b1;
    at(b0 + 80);
    check("midreset_count_norep", log2[2].size(), 1);
    check("midreset_time_norep",  first2(2), b0 + 28);
    check("midreset_time_rep",    first1(2), b0 + 28);

    // Short glitch on Right: D-1 low samples
    clear_logs(); b0 = cyc;
    at(b0 + 9);  raw[3] = 1'b0;
    at(b0 + 16); raw[3] = 1'b1;
    at(b0 + 50);
    tot1 = 0; tot2 = 0;
    for (int b = 0; b < 4; b++) begin
      tot1 += log1[b].size();
      tot2 += log2[b].size();
    end
    check("glitch_pulses_rep",   tot1, 0);
    check("glitch_pulses_norep", tot2, 0);

    // Random per-button run lengths, checked cycle by cycle against the model
    for (int b = 0; b < 4; b++) run[b] = $urandom_range(1, 30);
    for (int n = 0; n < 2000; n++) begin
      at(cyc + 1);
      for (int b = 0; b < 4; b++) begin
        run[b]--;
        if (run[b] <= 0) begin
          raw[b] = ~raw[b];
          run[b] = $urandom_range(1, 30);
        end
      end
    end
    raw = 4'hF;
    at(cyc + 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
